mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set operand and HI/LO width; legal values are 8 to 64, even.
REQ-002 Port i_clock, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port i_reset, input, 1: synchronous reset, active-high.
REQ-004 Port i_start, input, 1: single-cycle operation request.
REQ-005 Port i_op, input, 3: operation code, encoded as 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
REQ-006 Ports i_opA and i_opB, input, DATA_WIDTH each: rs/rt operands (dividend and divisor for divides).
REQ-007 Port i_flush, input, 1: abort the operation in flight.
REQ-008 Ports o_hi and o_lo, output, DATA_WIDTH each: architectural HI/LO registers.
REQ-009 Port o_busy, output, 1: high while an operation is in progress; feeds the pipeline stall.
REQ-010 Port o_done, output, 1: one-cycle pulse when HI/LO receive a new result.
REQ-011 Port o_div_zero, output, 1: sticky divide-by-zero flag, cleared by the next accepted i_start.

Function
REQ-012 The state machine SHALL have states IDLE, RUN and FIX.
- IDLE to RUN on an accepted multiply or divide.
- RUN to FIX after the last iteration.
- FIX to IDLE after one cycle.
REQ-013 i_start SHALL be accepted only in IDLE; i_start while o_busy=1 SHALL be ignored with no side effects.
REQ-014 MULT/MULTU SHALL use shift-add, one bit per cycle, DATA_WIDTH RUN cycles; {HI,LO} SHALL receive the 2*DATA_WIDTH-bit product.
REQ-015 DIV/DIVU SHALL use restoring division, one quotient bit per cycle, DATA_WIDTH RUN cycles; LO SHALL receive the quotient and HI the remainder.
REQ-016 Signed ops SHALL latch operand magnitudes at start.
- FIX SHALL negate the product when the operand signs differ.
- FIX SHALL negate the quotient when the signs differ and the remainder when the dividend is negative (truncate toward zero).
REQ-017 Unsigned ops SHALL pass through FIX unchanged.
REQ-018 Latency: with start accepted at edge N, HI/LO SHALL update and o_done SHALL pulse at edge N+DATA_WIDTH+1; o_busy SHALL be high from N+1 through N+DATA_WIDTH+1 inclusive.
REQ-019 HI/LO SHALL NOT change during RUN; intermediate results SHALL live in internal registers only.
REQ-020 Divisor 0 SHALL skip RUN: at edge N+1, HI=dividend, LO=all ones, o_div_zero=1, o_done pulses, and the unit returns to IDLE.
REQ-021 Signed DIV of the most-negative value by -1 SHALL give LO=most-negative value and HI=0, with no flag.
REQ-022 MTHI/MTLO SHALL write i_opA to HI/LO at the next edge, with no busy cycle and no o_done.
REQ-023 i_flush in RUN or FIX SHALL return the unit to IDLE at the next edge with HI/LO unchanged and no o_done; i_flush in IDLE SHALL have no effect.
REQ-024 Simultaneous i_flush and i_start in IDLE: i_flush SHALL win and the start SHALL be dropped.
REQ-025 The iteration counter SHALL be $clog2(DATA_WIDTH)+1 bits wide and SHALL NOT wrap during an operation.

Reset
REQ-026 i_reset SHALL take priority over every other input.
REQ-027 i_reset SHALL force state IDLE, o_hi=0, o_lo=0, o_busy=0, o_done=0, o_div_zero=0, and clear the counter and internal accumulators.
REQ-028 Reset asserted mid-operation SHALL discard the operation entirely.

Configuration
REQ-029 Macro MULT_DIV_DIVIDE_EN defined: divide support SHALL be compiled in as specified above.
REQ-030 Macro MULT_DIV_DIVIDE_EN undefined:
- divider logic SHALL be absent;
- DIV/DIVU SHALL be treated as no-ops (no busy, HI/LO unchanged);
- o_div_zero SHALL be tied to 0.

Structure
REQ-031 The i_op encodings and the state encodings SHALL be defined as constants in the shared mips_pkg package.
REQ-032 One sub-module, mult_div_step, SHALL hold the combinational single-iteration datapath (add/shift or subtract/restore), selected by a mode bit.

Verification
REQ-033 DATA_WIDTH=32, MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, o_done at start+33.
REQ-034 MULT -7 x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-035 DIVU 100 / 0 -> HI=100, LO=0xFFFFFFFF, o_div_zero=1, o_done at start+1; a following MTLO 5 -> LO=5, flag still set.
REQ-036 MULTU 3 x 4 with i_flush at cycle 10 -> o_busy low next cycle, HI/LO keep their prior values, no o_done.
REQ-037 Second i_start during busy -> ignored, first result correct; i_reset at cycle 5 -> all outputs 0 next edge.
REQ-038 DATA_WIDTH=8 regression, with and without MULT_DIV_DIVIDE_EN: DIV 0x80 / 0xFF -> LO=0x80, HI=0 with the macro defined; HI/LO unchanged with it undefined.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the multiply/divide unit: operation codes and FSM state encoding.
package mips_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/mult_div_step.sv
// One iteration of the iterative multiplier (shift-add) or divider (restoring), chosen by mode.
// The divide path exists only when MULT_DIV_DIVIDE_EN is defined.
module mult_div_step #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  mode,
   input  logic [DATA_WIDTH-1:0] hi,
   input  logic [DATA_WIDTH-1:0] lo,
   input  logic [DATA_WIDTH-1:0] operand,
   output logic [DATA_WIDTH-1:0] hi_next,
   output logic [DATA_WIDTH-1:0] lo_next
);

   logic [DATA_WIDTH:0] sum_s;

   assign sum_s = {1'b0, hi} + {1'b0, operand};

`ifdef MULT_DIV_DIVIDE_EN
   logic [DATA_WIDTH-1:0] shl_s;
   logic                  ge_s;

   // A set top remainder bit means the shifted value already exceeds any divisor.
   assign shl_s = {hi[DATA_WIDTH-2:0], lo[DATA_WIDTH-1]};
   assign ge_s  = hi[DATA_WIDTH-1] || (shl_s >= operand);

   // Divide: shift remainder in, trial-subtract; multiply: conditional add then shift right.
   always_comb begin
      hi_next = hi;
      lo_next = lo;
      if (mode) begin
         if (ge_s) begin
            hi_next = shl_s - operand;
         end else begin
            hi_next = shl_s;
         end
         lo_next = {lo[DATA_WIDTH-2:0], ge_s};
      end else if (lo[0]) begin
         {hi_next, lo_next} = {sum_s, lo[DATA_WIDTH-1:1]};
      end else begin
         {hi_next, lo_next} = {1'b0, hi, lo[DATA_WIDTH-1:1]};
      end
   end
`else
   // Multiply only: mode forces a plain shift without the add.
   always_comb begin
      hi_next = hi;
      lo_next = lo;
      if (lo[0] && !mode) begin
         {hi_next, lo_next} = {sum_s, lo[DATA_WIDTH-1:1]};
      end else begin
         {hi_next, lo_next} = {1'b0, hi, lo[DATA_WIDTH-1:1]};
      end
   end
`endif

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit (IDLE/RUN/FIX FSM, one bit per cycle).
// Divide support is compiled in only when MULT_DIV_DIVIDE_EN is defined.
module mult_div_unit
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [2:0]            i_op,
   input  logic [DATA_WIDTH-1:0] i_opA,
   input  logic [DATA_WIDTH-1:0] i_opB,
   input  logic                  i_flush,
   output logic [DATA_WIDTH-1:0] o_hi,
   output logic [DATA_WIDTH-1:0] o_lo,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_div_zero
);

   localparam int              CW        = $clog2(DATA_WIDTH) + 1;
   localparam logic [CW-1:0]   LAST_STEP = CW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

   state_t                  state_r, state_s;
   logic [CW-1:0]           count_r;
   logic [DATA_WIDTH-1:0]   hi_r, lo_r, acc_hi_r, acc_lo_r, opb_r;
   logic                    is_div_r, zero_r, neg_res_r, neg_rem_r, busy_r, done_r;

   logic                    accept_s, launch_s, is_mul_s, is_div_s, signed_s, zero_s;
   logic                    a_neg_s, b_neg_s;
   logic [DATA_WIDTH-1:0]   a_mag_s, b_mag_s, step_hi_s, step_lo_s, fix_hi_s, fix_lo_s;
   logic [2*DATA_WIDTH-1:0] neg_prod_s;

   assign accept_s = (state_r == ST_IDLE) && i_start && !i_flush;
   assign is_mul_s = (i_op == OP_MULT) || (i_op == OP_MULTU);
`ifdef MULT_DIV_DIVIDE_EN
   assign is_div_s = (i_op == OP_DIV) || (i_op == OP_DIVU);
`else
   assign is_div_s = 1'b0;
`endif
   assign launch_s = accept_s && (is_mul_s || is_div_s);
   assign zero_s   = is_div_s && (i_opB == '0);
   assign signed_s = (i_op == OP_MULT) || (i_op == OP_DIV);
   assign a_neg_s  = signed_s && i_opA[DATA_WIDTH-1];
   assign b_neg_s  = signed_s && i_opB[DATA_WIDTH-1];
   assign a_mag_s  = a_neg_s ? -i_opA : i_opA;
   assign b_mag_s  = b_neg_s ? -i_opB : i_opB;

   mult_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .mode    (is_div_r),
      .hi      (acc_hi_r),
      .lo      (acc_lo_r),
      .operand (opb_r),
      .hi_next (step_hi_s),
      .lo_next (step_lo_s)
   );

   assign neg_prod_s = -{acc_hi_r, acc_lo_r};

   // Sign fix-up: quotient takes the sign XOR, remainder follows the dividend.
   always_comb begin
      fix_hi_s = acc_hi_r;
      fix_lo_s = acc_lo_r;
      if (zero_r) begin
         fix_hi_s = acc_lo_r;
         fix_lo_s = '1;
      end else if (is_div_r) begin
         fix_lo_s = neg_res_r ? -acc_lo_r : acc_lo_r;
         fix_hi_s = neg_rem_r ? -acc_hi_r : acc_hi_r;
      end else if (neg_res_r) begin
         {fix_hi_s, fix_lo_s} = neg_prod_s;
      end else begin
         fix_hi_s = acc_hi_r;
         fix_lo_s = acc_lo_r;
      end
   end

   // Next-state logic; a zero divisor jumps straight to FIX.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (launch_s) begin
               state_s = zero_s ? ST_FIX : ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (i_flush) begin
               state_s = ST_IDLE;
            end else if (count_r == LAST_STEP) begin
               state_s = ST_FIX;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_FIX:  state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // State, datapath accumulators and architectural HI/LO.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_r   <= ST_IDLE;
         count_r   <= '0;
         hi_r      <= '0;
         lo_r      <= '0;
         acc_hi_r  <= '0;
         acc_lo_r  <= '0;
         opb_r     <= '0;
         is_div_r  <= 1'b0;
         zero_r    <= 1'b0;
         neg_res_r <= 1'b0;
         neg_rem_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != ST_IDLE);
         done_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (launch_s) begin
                  count_r   <= '0;
                  is_div_r  <= is_div_s;
                  zero_r    <= zero_s;
                  neg_res_r <= a_neg_s ^ b_neg_s;
                  neg_rem_r <= a_neg_s;
                  acc_hi_r  <= '0;
                  acc_lo_r  <= zero_s ? i_opA : a_mag_s;
                  opb_r     <= b_mag_s;
               end else if (accept_s && (i_op == OP_MTHI)) begin
                  hi_r <= i_opA;
               end else if (accept_s && (i_op == OP_MTLO)) begin
                  lo_r <= i_opA;
               end
            end
            ST_RUN: begin
               if (!i_flush) begin
                  acc_hi_r <= step_hi_s;
                  acc_lo_r <= step_lo_s;
                  count_r  <= count_r + CNT_ONE;
               end
            end
            ST_FIX: begin
               if (!i_flush) begin
                  hi_r   <= fix_hi_s;
                  lo_r   <= fix_lo_s;
                  done_r <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MULT_DIV_DIVIDE_EN
   logic div_zero_r;

   // Sticky divide-by-zero flag, cleared when the next multiply/divide launches.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         div_zero_r <= 1'b0;
      end else if (launch_s) begin
         div_zero_r <= 1'b0;
      end else if ((state_r == ST_FIX) && !i_flush && zero_r) begin
         div_zero_r <= 1'b1;
      end else begin
         div_zero_r <= div_zero_r;
      end
   end

   assign o_div_zero = div_zero_r;
`else
   assign o_div_zero = 1'b0;
`endif

   assign o_hi   = hi_r;
   assign o_lo   = lo_r;
   assign o_busy = busy_r;
   assign o_done = done_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit at DATA_WIDTH=32, plus an 8-bit instance.
module tb_mult_div_unit;

   localparam int W = 32;
`ifdef MULT_DIV_DIVIDE_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif
   localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3, MTHI = 3'd4, MTLO = 3'd5;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } res_t;

   logic         clock = 1'b0;
   logic         reset = 1'b1, start = 1'b0, flush = 1'b0;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] opa = '0, opb = '0;
   logic [W-1:0] o_hi, o_lo;
   logic         o_busy, o_done, o_div_zero;

   logic         start8 = 1'b0;
   logic [2:0]   op8 = 3'd0;
   logic [7:0]   opa8 = 8'h00, opb8 = 8'h00, hi8, lo8;
   logic         busy8, done8, dz8;

   int           errors = 0, checks = 0;
   res_t         sb_q[$];
   logic [W-1:0] hi_m, lo_m;
   logic         dz_m;

   always #5 clock = ~clock;

   mult_div_unit #(.DATA_WIDTH(W)) dut (
      .i_clock(clock), .i_reset(reset), .i_start(start), .i_op(op), .i_opA(opa), .i_opB(opb),
      .i_flush(flush), .o_hi(o_hi), .o_lo(o_lo), .o_busy(o_busy), .o_done(o_done), .o_div_zero(o_div_zero)
   );

   mult_div_unit #(.DATA_WIDTH(8)) dut8 (
      .i_clock(clock), .i_reset(reset), .i_start(start8), .i_op(op8), .i_opA(opa8), .i_opB(opb8),
      .i_flush(1'b0), .o_hi(hi8), .o_lo(lo8), .o_busy(busy8), .o_done(done8), .o_div_zero(dz8)
   );

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      op = o; opa = a; opb = b; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic predict(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output bit md, output int lat);
      res_t r;
      logic [2*W-1:0] pa, pb, pp;
      longint sa, sb, q, rm;
      logic [63:0] qv, rv;
      md = 1'b0; lat = W + 1;
      r.hi = '0; r.lo = '0; r.dz = 1'b0;
      case (o)
         MULT, MULTU: begin
            pa = (o == MULT) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
            pb = (o == MULT) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
            pp = pa * pb;
            r.hi = pp[2*W-1:W]; r.lo = pp[W-1:0]; md = 1'b1;
         end
         DIV, DIVU: begin
            if (DIV_EN) begin
               md = 1'b1;
               if (b == '0) begin
                  r.hi = a; r.lo = '1; r.dz = 1'b1; lat = 1;
               end else begin
                  sa = (o == DIV) ? longint'($signed(a)) : longint'(a);
                  sb = (o == DIV) ? longint'($signed(b)) : longint'(b);
                  q = sa / sb; rm = sa % sb;
                  qv = q; rv = rm;
                  r.lo = qv[W-1:0]; r.hi = rv[W-1:0];
               end
            end
         end
         MTHI:    hi_m = a;
         MTLO:    lo_m = a;
         default: ;
      endcase
      if (md) begin
         sb_q.push_back(r);
         hi_m = r.hi; lo_m = r.lo; dz_m = r.dz;
      end
   endtask

   task automatic wait_check(input int lat0, input int exp_lat, input string name);
      int lat;
      bit seen;
      res_t e;
      lat = lat0; seen = 1'b0;
      while (!seen && lat < lat0 + W + 8) begin
         @(negedge clock);
         lat++;
         if (o_done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s done: seen=%0d queued=%0d after %0d cycles, expected one o_done", name, seen, sb_q.size(), lat);
         if (sb_q.size() > 0) sb_q.delete(0);
      end else begin
         e = sb_q.pop_front();
         checks++;
         if (lat !== exp_lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat); end
         checks++;
         if (o_hi !== e.hi || o_lo !== e.lo) begin
            errors++; $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h", name, o_hi, o_lo, e.hi, e.lo);
         end
         checks++;
         if (o_div_zero !== e.dz) begin errors++; $display("FAIL %s div_zero: got %b expected %b", name, o_div_zero, e.dz); end
         @(negedge clock);
         checks++;
         if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL %s after_done: done=%b busy=%b expected 0 0", name, o_done, o_busy);
         end
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
      bit md;
      int lat;
      predict(o, a, b, md, lat);
      issue(o, a, b);
      checks++;
      if (md) begin
         if (o_busy !== 1'b1) begin errors++; $display("FAIL %s busy_start: got %b expected 1", name, o_busy); end
         wait_check(0, lat, name);
      end else begin
         if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++; $display("FAIL %s no_busy: busy=%b done=%b expected 0 0", name, o_busy, o_done);
         end
      end
      checks++;
      if (o_hi !== hi_m || o_lo !== lo_m || o_div_zero !== dz_m) begin
         errors++; $display("FAIL %s state: hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b", name, o_hi, o_lo, o_div_zero, hi_m, lo_m, dz_m);
      end
   endtask

   task automatic expect_quiet(input int cycles, input string name);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clock);
         if (o_done === 1'b1) seen++;
      end
      checks++;
      if (seen != 0 || o_hi !== hi_m || o_lo !== lo_m) begin
         errors++; $display("FAIL %s quiet: dones=%0d hi=%h lo=%h expected 0 dones hi=%h lo=%h", name, seen, o_hi, o_lo, hi_m, lo_m);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if (o_hi !== '0 || o_lo !== '0 || {o_busy, o_done, o_div_zero} !== 3'b000) begin
         errors++; $display("FAIL reset_state: hi=%h lo=%h busy/done/dz=%b expected all 0", o_hi, o_lo, {o_busy, o_done, o_div_zero});
      end
      checks++;
      if (hi8 !== 8'h00 || lo8 !== 8'h00 || {busy8, done8, dz8} !== 3'b000) begin
         errors++; $display("FAIL reset_state8: hi=%h lo=%h flags=%b expected all 0", hi8, lo8, {busy8, done8, dz8});
      end
      reset = 1'b0;
      hi_m = '0; lo_m = '0; dz_m = 1'b0; sb_q.delete();
   endtask

   task automatic test_mult();
      run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      checks++;
      if (o_hi !== 32'hFFFF_FFFE || o_lo !== 32'h0000_0001) begin
         errors++; $display("FAIL multu_max_const: got %h_%h expected FFFFFFFE_00000001", o_hi, o_lo);
      end
      run_op(MULT, -32'sd7, 32'sd3, "mult_neg7x3");
      checks++;
      if (o_hi !== 32'hFFFF_FFFF || o_lo !== 32'hFFFF_FFEB) begin
         errors++; $display("FAIL mult_neg7x3_const: got %h_%h expected FFFFFFFF_FFFFFFEB", o_hi, o_lo);
      end
      run_op(MULT, 32'h8000_0000, 32'h8000_0000, "mult_min_min");
      run_op(MULT, 32'hFFFF_FFFB, 32'h0000_0000, "mult_neg_zero");
      run_op(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1_m1");
      for (int i = 0; i < 4; i++) run_op(($urandom_range(1, 0) == 0) ? MULT : MULTU, $urandom, $urandom, "mult_rand");
   endtask

   task automatic test_div();
      logic [W-1:0] b;
      run_op(DIV, -32'sd7, 32'sd2, "div_neg7by2");
      run_op(DIV, 32'sd7, -32'sd2, "div_7byneg2");
      run_op(DIVU, 32'd100, 32'd7, "divu_100by7");
      run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_by_m1");
      run_op(DIVU, 32'hFFFF_FFFF, 32'h8000_0001, "divu_big");
      run_op(DIVU, 32'd100, 32'd0, "divu_by_zero");
      run_op(MTLO, 32'd5, 32'd0, "mtlo_after_dz");
      run_op(MTHI, 32'h1234_5678, 32'd0, "mthi");
      run_op(MULTU, 32'd2, 32'd3, "mult_clears_dz");
      for (int i = 0; i < 4; i++) begin
         b = $urandom;
         if (b == '0) b = 32'd1;
         run_op(($urandom_range(1, 0) == 0) ? DIV : DIVU, $urandom, b, "div_rand");
      end
      run_op(3'd6, 32'hAAAA_AAAA, 32'd1, "noop6");
      run_op(3'd7, 32'h5555_5555, 32'd1, "noop7");
   endtask

   task automatic test_flush();
      issue(MULTU, 32'd3, 32'd4);
      repeat (9) @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
         errors++; $display("FAIL flush_run: busy=%b done=%b expected 0 0", o_busy, o_done);
      end
      expect_quiet(W + 4, "flush_run");
      issue(MULT, 32'd9, 32'd9);
      repeat (W) @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_hi !== hi_m || o_lo !== lo_m) begin
         errors++; $display("FAIL flush_fix: busy=%b done=%b hi=%h lo=%h expected 0 0 %h %h", o_busy, o_done, o_hi, o_lo, hi_m, lo_m);
      end
      flush = 1'b1;
      issue(MTHI, 32'hCAFE_F00D, 32'd0);
      issue(MULTU, 32'd5, 32'd5);
      flush = 1'b0;
      checks++;
      if (o_busy !== 1'b0 || o_hi !== hi_m) begin
         errors++; $display("FAIL flush_idle_start: busy=%b hi=%h expected 0 %h", o_busy, o_hi, hi_m);
      end
      expect_quiet(W + 4, "flush_idle");
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] held_hi;
      bit md;
      int lat;
      held_hi = hi_m;
      predict(MULT, 32'd1000, -32'sd3, md, lat);
      issue(MULT, 32'd1000, -32'sd3);
      repeat (2) @(negedge clock);
      issue(MTHI, 32'hDEAD_BEEF, 32'd0);
      checks++;
      if (o_hi !== held_hi || o_busy !== 1'b1) begin
         errors++; $display("FAIL busy_ignore_mthi: hi=%h busy=%b expected %h 1", o_hi, o_busy, held_hi);
      end
      issue(MULTU, 32'd7, 32'd7);
      wait_check(4, lat, "busy_ignore");
      expect_quiet(3, "busy_ignore_tail");
      run_op(MULTU, 32'd11, 32'd13, "b2b_a");
      run_op(DIVU, 32'd1000, 32'd33, "b2b_b");
      run_op(MULT, -32'sd1, 32'sd1, "b2b_c");
   endtask

   task automatic test_reset_mid();
      run_op(MTHI, 32'hA5A5_A5A5, 32'd0, "pre_reset_mthi");
      issue(MULTU, 32'd5, 32'd6);
      repeat (4) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checks++;
      if (o_hi !== '0 || o_lo !== '0 || {o_busy, o_done, o_div_zero} !== 3'b000) begin
         errors++; $display("FAIL reset_mid: hi=%h lo=%h flags=%b expected all 0", o_hi, o_lo, {o_busy, o_done, o_div_zero});
      end
      hi_m = '0; lo_m = '0; dz_m = 1'b0; sb_q.delete();
      expect_quiet(W + 4, "reset_mid");
   endtask

   task automatic test_width8();
      int lat;
      bit seen;
      op8 = MULTU; opa8 = 8'hFF; opb8 = 8'hFF; start8 = 1'b1;
      @(negedge clock);
      start8 = 1'b0;
      lat = 0; seen = 1'b0;
      while (!seen && lat < 20) begin
         @(negedge clock); lat++;
         if (done8 === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || lat != 9 || hi8 !== 8'hFE || lo8 !== 8'h01) begin
         errors++; $display("FAIL w8_multu: seen=%0d lat=%0d hi=%h lo=%h expected 1 9 fe 01", seen, lat, hi8, lo8);
      end
      op8 = DIV; opa8 = 8'h80; opb8 = 8'hFF; start8 = 1'b1;
      @(negedge clock);
      start8 = 1'b0;
      lat = 0; seen = 1'b0;
      while (!seen && lat < 14) begin
         @(negedge clock); lat++;
         if (done8 === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== DIV_EN || hi8 !== (DIV_EN ? 8'h00 : 8'hFE) || lo8 !== (DIV_EN ? 8'h80 : 8'h01) || dz8 !== 1'b0) begin
         errors++; $display("FAIL w8_div_min: seen=%0d hi=%h lo=%h dz=%b expected seen=%0d hi=%h lo=%h dz=0",
                            seen, hi8, lo8, dz8, DIV_EN, DIV_EN ? 8'h00 : 8'hFE, DIV_EN ? 8'h80 : 8'h01);
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      test_width8();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
